// File: rtl/ft_tx_arbiter_if.sv
// ft_tx_arbiter_if: requester streams plus FT bridge write port shared by the TX arbiter.
interface ft_tx_arbiter_if #(
  parameter int BUS_WIDTH = 16,
  parameter int CHANNELS  = 4
);
  logic [CHANNELS*BUS_WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]           ch_valid;
  logic [CHANNELS-1:0]           ch_last;
  logic [CHANNELS-1:0]           ch_ready;
  logic [BUS_WIDTH-1:0]          ft_din;
  logic [BUS_WIDTH/8-1:0]        ft_din_be;
  logic                          ft_din_valid;
  logic                          ft_din_full;
  logic                          busy;
  logic [3:0]                    grant_ch;
  modport master (
    input  ch_data, ch_valid, ch_last, ft_din_full,
    output ch_ready, ft_din, ft_din_be, ft_din_valid, busy, grant_ch
  );
  modport slave (
    output ch_data, ch_valid, ch_last, ft_din_full,
    input  ch_ready, ft_din, ft_din_be, ft_din_valid, busy, grant_ch
  );
endinterface

// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter: round-robin packetiser of CHANNELS streams onto the FT bridge write port.
// Optional FT_ARB_TIMEOUT_EN closes a stalled DATA phase with a 4'h6 trailer.
module ft_tx_arbiter #(
  parameter int BUS_WIDTH      = 16,
  parameter int CHANNELS       = 4,
  parameter int MAX_BURST      = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst_n,
  ft_tx_arbiter_if.master bus
);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;
  state_t state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [7:0] count_q, count_d;
  logic [CW-1:0] gsel;
  logic [3:0] tag;
  logic cur_valid, cur_last, full;
  logic [BUS_WIDTH-1:0] cur_data;
`ifdef FT_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic to_q, to_d;
  assign tag = to_q ? 4'h6 : 4'h5;
`else
  assign tag = 4'h5;
`endif
  assign gsel          = grant_q[CW-1:0];
  assign full          = bus.ft_din_full;
  assign cur_valid     = bus.ch_valid[gsel];
  assign cur_last      = bus.ch_last[gsel];
  assign cur_data      = bus.ch_data[int'(gsel)*BUS_WIDTH +: BUS_WIDTH];
  assign bus.ft_din_be = '1;
  assign bus.busy      = state_q != IDLE;
  assign bus.grant_ch  = grant_q;
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    count_d          = count_q;
    bus.ch_ready     = '0;
    bus.ft_din       = '0;
    bus.ft_din_valid = 1'b0;
`ifdef FT_ARB_TIMEOUT_EN
    stall_d          = stall_q;
    to_d             = to_q;
`endif
    case (state_q)
      IDLE: begin
        // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
        for (int i = CHANNELS - 1; i >= 0; i--)
          if (bus.ch_valid[i] && i <= int'(grant_q)) begin
            grant_d = 4'(i);
            state_d = HEADER;
          end
        for (int i = CHANNELS - 1; i >= 0; i--)
          if (bus.ch_valid[i] && i > int'(grant_q)) begin
            grant_d = 4'(i);
            state_d = HEADER;
          end
      end
      HEADER: begin
        bus.ft_din       = BUS_WIDTH'({4'hA, grant_q, 8'h00});
        bus.ft_din_valid = !full;
        count_d          = full ? count_q : 8'd0;
        state_d          = full ? HEADER : DATA;
`ifdef FT_ARB_TIMEOUT_EN
        stall_d          = '0;
        to_d             = 1'b0;
`endif
      end
      DATA: begin
        bus.ch_ready[gsel] = !full;
        bus.ft_din         = cur_data;
        bus.ft_din_valid   = cur_valid && !full;
        if (cur_valid && !full) begin
          count_d = count_q + 8'd1;
          state_d = (cur_last || count_q + 8'd1 == 8'(MAX_BURST)) ? TRAILER : DATA;
        end
`ifdef FT_ARB_TIMEOUT_EN
        stall_d = cur_valid ? '0 : stall_q + 1'b1;
        if (!cur_valid && stall_q + 1'b1 == SW'(TIMEOUT_CYCLES)) begin
          state_d = TRAILER;
          to_d    = 1'b1;
        end
`endif
      end
      default: begin
        bus.ft_din       = BUS_WIDTH'({tag, grant_q, count_q});
        bus.ft_din_valid = !full;
        state_d          = full ? TRAILER : IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'(CHANNELS - 1);
      count_q <= '0;
`ifdef FT_ARB_TIMEOUT_EN
      stall_q <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
`ifdef FT_ARB_TIMEOUT_EN
      stall_q <= stall_d;
      to_q    <= to_d;
`endif
    end
  end
endmodule

// File: tb/tb_ft_tx_arbiter.sv
// tb_ft_tx_arbiter: directed stimulus into per-channel queues, expected FT words
// into a scoreboard queue checked by an independent bus monitor.
module tb_ft_tx_arbiter;
  localparam int BW = 16;
  localparam int CH = 4;
  localparam int MB = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ft_tx_arbiter_if #(.BUS_WIDTH(BW), .CHANNELS(CH)) bus ();
  ft_tx_arbiter #(.BUS_WIDTH(BW), .CHANNELS(CH), .MAX_BURST(MB), .TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  logic [BW-1:0] exp_q[$];
  logic [BW:0]   chq[CH][$];
  logic [CH-1:0] fire = '0;
  int full_cnt = 0, full_seen = 0, checks = 0, failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    fire = bus.ch_valid & bus.ch_ready;
    if (bus.ft_din_full) begin
      full_seen++;
      check("full_gate", {30'd0, bus.ft_din_valid, |bus.ch_ready}, 32'd0);
    end
    if (bus.ft_din_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", bus.ft_din);
      end else begin
        check("ft_din", bus.ft_din, exp_q.pop_front());
        check("ft_din_be", bus.ft_din_be, 2'b11);
      end
    end
  end

  initial begin
    bus.ch_valid = '0;
    bus.ch_last = '0;
    bus.ch_data = '0;
    bus.ft_din_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < CH; i++) begin
        if (fire[i] && chq[i].size() > 0) void'(chq[i].pop_front());
        bus.ch_valid[i] = chq[i].size() > 0;
        bus.ch_last[i] = chq[i].size() > 0 ? chq[i][0][BW] : 1'b0;
        bus.ch_data[i*BW +: BW] = chq[i].size() > 0 ? chq[i][0][BW-1:0] : '0;
      end
      bus.ft_din_full = full_cnt > 0;
      if (full_cnt > 0) full_cnt--;
    end
  end

  task automatic push_ch(int c, logic [BW-1:0] d, logic last);
    chq[c].push_back({last, d});
  endtask

  task automatic expect_w(logic [BW-1:0] w);
    exp_q.push_back(w);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.ft_din_valid, 0);
    check("rst_ready", bus.ch_ready, 0);
    check("rst_din", bus.ft_din, 0);
    check("rst_grant", bus.grant_ch, CH - 1);
    for (int i = 0; i < CH; i++) chq[i].delete();
    exp_q.delete();
    fire = '0;
    full_cnt = 0;
    bus.ch_valid = '0;
    bus.ch_last = '0;
    bus.ft_din_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #12;
    reset_pulse();
    // single 3-word packet on channel 2
    foreach (exp_q[i]) ;
    expect_w(16'hA200); expect_w(16'h1111); expect_w(16'h2222); expect_w(16'h3333); expect_w(16'h5203);
    push_ch(2, 16'h1111, 0); push_ch(2, 16'h2222, 0); push_ch(2, 16'h3333, 1);
    drain(200);
    @(negedge clk);
    #1;
    check("busy_after_trailer", bus.busy, 0);
    // all channels requesting: round-robin order 0,1,2,3,0
    @(negedge clk);
    reset_pulse();
    push_ch(0, 16'h0A01, 1); push_ch(0, 16'h0A02, 1);
    push_ch(1, 16'h0B01, 1); push_ch(2, 16'h0C01, 1); push_ch(3, 16'h0D01, 1);
    expect_w(16'hA000); expect_w(16'h0A01); expect_w(16'h5001);
    expect_w(16'hA100); expect_w(16'h0B01); expect_w(16'h5101);
    expect_w(16'hA200); expect_w(16'h0C01); expect_w(16'h5201);
    expect_w(16'hA300); expect_w(16'h0D01); expect_w(16'h5301);
    expect_w(16'hA000); expect_w(16'h0A02); expect_w(16'h5001);
    drain(300);
    // 70-word stream on channel 1 split at MAX_BURST, channel 2 served in between
    reset_pulse();
    for (int i = 0; i < 70; i++) push_ch(1, 16'(16'h1000 + i), i == 69);
    push_ch(2, 16'hBEEF, 1);
    expect_w(16'hA100);
    for (int i = 0; i < 64; i++) expect_w(16'(16'h1000 + i));
    expect_w(16'h5140);
    expect_w(16'hA200); expect_w(16'hBEEF); expect_w(16'h5201);
    expect_w(16'hA100);
    for (int i = 64; i < 70; i++) expect_w(16'(16'h1000 + i));
    expect_w(16'h5106);
    drain(1000);
    // bridge full for 10 cycles in the middle of DATA
    reset_pulse();
    full_seen = 0;
    for (int i = 0; i < 6; i++) push_ch(2, 16'(16'h2000 + i), i == 5);
    expect_w(16'hA200);
    for (int i = 0; i < 6; i++) expect_w(16'(16'h2000 + i));
    expect_w(16'h5206);
    for (int n = 0; n < 200 && exp_q.size() > 5; n++) @(negedge clk);
    #1;
    full_cnt = 10;
    drain(300);
    check("full_cycles", full_seen, 10);
    // asynchronous reset mid-DATA, then a fresh packet
    reset_pulse();
    push_ch(3, 16'h3AAA, 0); push_ch(3, 16'h3BBB, 0);
    expect_w(16'hA300); expect_w(16'h3AAA); expect_w(16'h3BBB);
    drain(200);
    repeat (3) @(negedge clk);
    #2;
    check("busy_mid_data", bus.busy, 1);
    reset_pulse();
    push_ch(3, 16'h3CCC, 1);
    expect_w(16'hA300); expect_w(16'h3CCC); expect_w(16'h5301);
    drain(200);
`ifdef FT_ARB_TIMEOUT_EN
    reset_pulse();
    push_ch(0, 16'h0101, 0); push_ch(0, 16'h0202, 0);
    expect_w(16'hA000); expect_w(16'h0101); expect_w(16'h0202); expect_w(16'h6002);
    drain(600);
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
